// File: rtl/cache_bus_arbiter_pkg.sv
// Shared cache-bus types and arbiter state encoding for cache_bus_arbiter.
package cache_bus_arbiter_pkg;

   localparam int DEFAULT_REQ_CNT = 2;

   typedef struct packed {
      logic        valid;
      logic        write;
      logic        cached;
      logic [31:0] addr;
      logic [7:0]  burst_size;
      logic [1:0]  data_size;
      logic [31:0] w_data;
      logic [3:0]  w_strb;
   } cache_bus_req_t;

   typedef struct packed {
      logic        ready;
      logic        data_ok;
      logic        data_last;
      logic [31:0] r_data;
   } cache_bus_resp_t;

   typedef enum logic [2:0] {
      ARB_IDLE = 3'b001,
      ARB_ADDR = 3'b010,
      ARB_DATA = 3'b100
   } cache_arb_fsm_t;

   // Value driven downstream whenever no requester owns the bus.
   function automatic cache_bus_req_t idle_req();
      cache_bus_req_t r;
      r = '0;
      r.data_size = 2'b10;
      return r;
   endfunction

   function automatic int idx_width(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cache_bus_arbiter_if.sv
// Requester-side and downstream cache-bus signals shared by the arbiter.
interface cache_bus_arbiter_if #(parameter int REQ_CNT = 2);
   import cache_bus_arbiter_pkg::*;

   cache_bus_req_t    req_i [REQ_CNT];
   cache_bus_resp_t   resp_o [REQ_CNT];
   logic [REQ_CNT-1:0] busy_o;
   cache_bus_req_t    bus_req_o;
   cache_bus_resp_t   bus_resp_i;

   modport master (input req_i, bus_resp_i, output resp_o, busy_o, bus_req_o);
   modport slave  (output req_i, bus_resp_i, input resp_o, busy_o, bus_req_o);

endinterface

// File: rtl/cache_bus_arb_pick.sv
// Combinational picker: the lowest set bit at or after ptr (wrapping) wins.
module cache_bus_arb_pick #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     valid,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] winner
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;

   assign dbl = {valid, valid};
   assign rot = N'(dbl >> ptr);

   // Scan downwards so the entry nearest the pointer is assigned last.
   always_comb begin
      any    = |valid;
      winner = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) winner = IDX_W'((int'(ptr) + i) % N);
      end
   end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Grants the downstream cache bus to one requester for a whole transaction.
// Define CACHE_BUS_ARB_RR_EN for round-robin; otherwise highest index wins.
module cache_bus_arbiter
   import cache_bus_arbiter_pkg::*;
#(
   parameter int REQ_CNT = DEFAULT_REQ_CNT
) (
   input logic clk,
   input logic rst_n,
   cache_bus_arbiter_if.master bus
);

   localparam int IDX_W = idx_width(REQ_CNT);

   cache_arb_fsm_t     state_q;
   logic [IDX_W-1:0]   owner_q;
   logic [REQ_CNT-1:0] valids;
   logic [REQ_CNT-1:0] pick_valid;
   logic [IDX_W-1:0]   pick_ptr;
   logic [IDX_W-1:0]   pick_idx;
   logic [IDX_W-1:0]   winner;
   logic               any_valid;

   always_comb begin
      for (int k = 0; k < REQ_CNT; k++) valids[k] = bus.req_i[k].valid;
   end

`ifdef CACHE_BUS_ARB_RR_EN
   logic [IDX_W-1:0] rr_q;

   assign pick_valid = valids;
   assign pick_ptr   = rr_q;
   assign winner     = pick_idx;
`else
   // Fixed priority reuses the picker on a bit-reversed request vector.
   always_comb begin
      for (int k = 0; k < REQ_CNT; k++) pick_valid[k] = valids[REQ_CNT-1-k];
   end
   assign pick_ptr = '0;
   assign winner   = IDX_W'(REQ_CNT - 1) - pick_idx;
`endif

   cache_bus_arb_pick #(.N(REQ_CNT), .IDX_W(IDX_W)) u_pick (
      .valid  (pick_valid),
      .ptr    (pick_ptr),
      .any    (any_valid),
      .winner (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         owner_q <= '0;
`ifdef CACHE_BUS_ARB_RR_EN
         rr_q    <= '0;
`endif
      end else begin
         case (state_q)
            ARB_IDLE: if (any_valid) begin
               owner_q <= winner;
               state_q <= ARB_ADDR;
`ifdef CACHE_BUS_ARB_RR_EN
               rr_q    <= (int'(winner) == REQ_CNT - 1) ? '0 : winner + 1'b1;
`endif
            end
            ARB_ADDR: if (bus.bus_resp_i.ready) state_q <= ARB_DATA;
            ARB_DATA: if (bus.bus_resp_i.data_ok && bus.bus_resp_i.data_last) state_q <= ARB_IDLE;
            default:  state_q <= ARB_IDLE;
         endcase
      end
   end

   // Outputs are forced quiet while rst_n is low so nothing leaks before state settles.
   always_comb begin
      bus.bus_req_o = idle_req();
      bus.busy_o    = '0;
      for (int k = 0; k < REQ_CNT; k++) bus.resp_o[k] = '0;
      if (rst_n) begin
         for (int k = 0; k < REQ_CNT; k++) begin
            if (state_q == ARB_IDLE) bus.busy_o[k] = any_valid && (winner != IDX_W'(k));
            else                     bus.busy_o[k] = (owner_q != IDX_W'(k));
         end
         case (state_q)
            ARB_ADDR: begin
               bus.bus_req_o             = bus.req_i[owner_q];
               bus.resp_o[owner_q].ready = bus.bus_resp_i.ready;
            end
            ARB_DATA: begin
               bus.bus_req_o       = bus.req_i[owner_q];
               bus.bus_req_o.valid = 1'b0;
               bus.resp_o[owner_q] = bus.bus_resp_i;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter: vector table, corner sequences, random run.
module tb_cache_bus_arbiter;
   import cache_bus_arbiter_pkg::*;

   localparam int N = 2;
   localparam logic [31:0] A0 = 32'h1C00_0010;
   localparam logic [31:0] A1 = 32'h2000_0040;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cache_bus_arbiter_if #(.REQ_CNT(N)) bus ();

   cache_bus_arbiter #(.REQ_CNT(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;

   // Transaction-level view: who owns the bus and whether its address was taken.
   int m_owner = -1;
   bit m_acc   = 1'b0;
   int m_rr    = 0;

   typedef struct {
      bit          v0;
      bit          v1;
      logic [1:0]  exp_busy;
      bit          exp_valid;
      logic [31:0] exp_addr1;
      bit          second;
      logic [31:0] exp_addr2;
   } vec_t;

   vec_t tv [4];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int model_pick();
`ifdef CACHE_BUS_ARB_RR_EN
      for (int j = 0; j < N; j++) begin
         int k;
         k = (m_rr + j) % N;
         if (bus.req_i[k].valid) return k;
      end
`else
      for (int k = N - 1; k >= 0; k--) if (bus.req_i[k].valid) return k;
`endif
      return -1;
   endfunction

   task automatic check_output();
      cache_bus_req_t  er;
      cache_bus_resp_t eresp [N];
      logic [N-1:0]    eb;
      int              w;
      er = idle_req();
      eb = '0;
      for (int k = 0; k < N; k++) eresp[k] = '0;
      if (rst_n) begin
         if (m_owner < 0) begin
            w = model_pick();
            for (int k = 0; k < N; k++) eb[k] = (w >= 0) && (w != k);
         end else begin
            for (int k = 0; k < N; k++) eb[k] = (k != m_owner);
            er = bus.req_i[m_owner];
            if (!m_acc) eresp[m_owner].ready = bus.bus_resp_i.ready;
            else begin
               er.valid = 1'b0;
               eresp[m_owner] = bus.bus_resp_i;
            end
         end
      end
      check("bus_req_o", 128'(bus.bus_req_o), 128'(er));
      for (int k = 0; k < N; k++) check($sformatf("resp_o[%0d]", k), 128'(bus.resp_o[k]), 128'(eresp[k]));
      check("busy_o", 128'(bus.busy_o), 128'(eb));
   endtask

   task automatic model_update();
      int w;
      if (!rst_n) begin
         m_owner = -1;
         m_acc   = 1'b0;
         m_rr    = 0;
      end else if (m_owner < 0) begin
         w = model_pick();
         if (w >= 0) begin
            m_owner = w;
            m_acc   = 1'b0;
            m_rr    = (w + 1) % N;
         end
      end else if (!m_acc) begin
         if (bus.bus_resp_i.ready) m_acc = 1'b1;
      end else if (bus.bus_resp_i.data_ok && bus.bus_resp_i.data_last) begin
         m_owner = -1;
      end
   endtask

   task automatic sample();
      @(negedge clk);
      check_output();
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic cycle();
      sample();
      advance();
   endtask

   task automatic set_req(input int k, input bit v, input bit w, input logic [31:0] a, input int burst);
      cache_bus_req_t r;
      r = '0;
      r.valid      = v;
      r.write      = w;
      r.cached     = (burst != 0);
      r.addr       = a;
      r.burst_size = 8'(burst);
      r.data_size  = 2'b10;
      r.w_data     = $urandom;
      r.w_strb     = 4'hF;
      bus.req_i[k] = r;
   endtask

   task automatic apply_stimulus(input bit rdy, input bit ok, input bit last, input logic [31:0] data);
      bus.bus_resp_i.ready     = rdy;
      bus.bus_resp_i.data_ok   = ok;
      bus.bus_resp_i.data_last = last;
      bus.bus_resp_i.r_data    = data;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int k = 0; k < N; k++) bus.req_i[k] = '0;
      apply_stimulus(0, 0, 0, 0);
      cycle();
      cycle();
      rst_n = 1'b1;
   endtask

   // Entered at the start of an ADDR cycle for requester k.
   task automatic finish_txn(input int k, input int beats);
      apply_stimulus(1, 0, 0, 0);
      cycle();
      bus.req_i[k].valid = 1'b0;
      for (int b = 0; b < beats; b++) begin
         apply_stimulus(0, 1, b == beats - 1, $urandom);
         cycle();
      end
      apply_stimulus(0, 0, 0, 0);
   endtask

   initial begin
      int pulses;
      int ok_count;
      bit active [N];

      tv[0] = '{1, 0, 2'b10, 1, A0, 0, 32'h0};
      tv[1] = '{0, 1, 2'b01, 1, A1, 0, 32'h0};
`ifdef CACHE_BUS_ARB_RR_EN
      tv[2] = '{1, 1, 2'b10, 1, A0, 1, A1};
`else
      tv[2] = '{1, 1, 2'b01, 1, A1, 1, A0};
`endif
      tv[3] = '{0, 0, 2'b00, 0, 32'h0, 0, 32'h0};

      do_reset();
      sample();
      check("reset busy_o", 128'(bus.busy_o), 128'(0));
      check("reset bus_req_o", 128'(bus.bus_req_o), 128'({1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 2'b10, 32'h0, 4'h0}));
      check("reset resp_o[0]", 128'(bus.resp_o[0]), 128'(0));
      advance();

      for (int i = 0; i < 4; i++) begin
         do_reset();
         set_req(0, tv[i].v0, 0, A0, 0);
         set_req(1, tv[i].v1, 0, A1, 0);
         sample();
         check("tbl busy", 128'(bus.busy_o), 128'(tv[i].exp_busy));
         advance();
         if (tv[i].exp_valid) apply_stimulus(1, 0, 0, 0);
         sample();
         check("tbl grant valid", 128'(bus.bus_req_o.valid), 128'(tv[i].exp_valid));
         check("tbl grant addr", 128'(bus.bus_req_o.addr), 128'(tv[i].exp_addr1));
         advance();
         if (tv[i].exp_valid) begin
            bus.req_i[(tv[i].exp_addr1 == A0) ? 0 : 1].valid = 1'b0;
            apply_stimulus(0, 1, 1, 32'hCAFE_0000 + 32'(i));
            cycle();
            apply_stimulus(0, 0, 0, 0);
            cycle();
            sample();
            check("tbl second valid", 128'(bus.bus_req_o.valid), 128'(tv[i].second));
            check("tbl second addr", 128'(bus.bus_req_o.addr), 128'(tv[i].exp_addr2));
            advance();
         end
      end

      // Single 4-beat cached read burst from fetch.
      do_reset();
      set_req(0, 1, 0, A0, 3);
      pulses = 0;
      ok_count = 0;
      sample();
      check("burst busy1 idle", 128'(bus.busy_o[1]), 128'(1));
      pulses += int'(bus.bus_req_o.valid);
      advance();
      apply_stimulus(1, 0, 0, 0);
      sample();
      check("burst addr", 128'(bus.bus_req_o.addr), 128'(A0));
      pulses += int'(bus.bus_req_o.valid);
      advance();
      bus.req_i[0].valid = 1'b0;
      for (int b = 0; b < 4; b++) begin
         apply_stimulus(0, 1, b == 3, 32'hD000_0000 + 32'(b));
         sample();
         check("burst busy1", 128'(bus.busy_o[1]), 128'(1));
         check("burst rdata", 128'(bus.resp_o[0].r_data), 128'(32'hD000_0000 + 32'(b)));
         check("burst last", 128'(bus.resp_o[0].data_last), 128'(b == 3));
         ok_count += int'(bus.resp_o[0].data_ok);
         pulses += int'(bus.bus_req_o.valid);
         advance();
      end
      apply_stimulus(0, 0, 0, 0);
      sample();
      check("burst valid pulses", 128'(pulses), 128'(1));
      check("burst data_ok count", 128'(ok_count), 128'(4));
      check("burst busy1 after", 128'(bus.busy_o[1]), 128'(0));
      advance();

      // Address stall with stray data strobes, then non-owner isolation in DATA.
      do_reset();
      set_req(1, 1, 0, A1, 2);
      cycle();
      for (int s = 0; s < 5; s++) begin
         if (s == 1) set_req(0, 1, 0, A0, 0);
         apply_stimulus(0, 1, 1, $urandom);
         sample();
         check("stall valid", 128'(bus.bus_req_o.valid), 128'(1));
         check("stall addr", 128'(bus.bus_req_o.addr), 128'(A1));
         check("stall no data", 128'(bus.resp_o[1].data_ok), 128'(0));
         advance();
      end
      apply_stimulus(1, 0, 0, 0);
      cycle();
      bus.req_i[1].valid = 1'b0;
      for (int b = 0; b < 3; b++) begin
         apply_stimulus(0, 1, b == 2, $urandom);
         sample();
         check("isolate resp0 data_ok", 128'(bus.resp_o[0].data_ok), 128'(0));
         check("isolate resp1 data_ok", 128'(bus.resp_o[1].data_ok), 128'(1));
         advance();
      end
      apply_stimulus(0, 0, 0, 0);
      sample();
      check("isolate idle busy", 128'(bus.busy_o), 128'(2'b10));
      advance();
      sample();
      check("isolate next grant addr", 128'(bus.bus_req_o.addr), 128'(A0));
      check("isolate next grant valid", 128'(bus.bus_req_o.valid), 128'(1));
      advance();
      finish_txn(0, 1);

      // Reset asserted on the second data beat abandons the transaction.
      do_reset();
      set_req(0, 1, 0, A0, 3);
      cycle();
      apply_stimulus(1, 0, 0, 0);
      cycle();
      bus.req_i[0].valid = 1'b0;
      apply_stimulus(0, 1, 0, $urandom);
      cycle();
      rst_n = 1'b0;
      apply_stimulus(0, 1, 0, $urandom);
      cycle();
      rst_n = 1'b1;
      apply_stimulus(0, 0, 0, 0);
      sample();
      check("rst resp0", 128'(bus.resp_o[0]), 128'(0));
      check("rst resp1", 128'(bus.resp_o[1]), 128'(0));
      check("rst busy", 128'(bus.busy_o), 128'(0));
      advance();
      set_req(0, 1, 0, A0 + 32'h100, 0);
      cycle();
      sample();
      check("rst regrant addr", 128'(bus.bus_req_o.addr), 128'(A0 + 32'h100));
      check("rst regrant valid", 128'(bus.bus_req_o.valid), 128'(1));
      advance();
      finish_txn(0, 1);

      // Uncached single-beat write from the data cache, fetch waiting behind it.
      do_reset();
      set_req(1, 1, 1, A1, 0);
      cycle();
      set_req(0, 1, 0, A0, 0);
      apply_stimulus(1, 0, 0, 0);
      sample();
      check("wr addr", 128'(bus.bus_req_o.addr), 128'(A1));
      check("wr write", 128'(bus.bus_req_o.write), 128'(1));
      advance();
      bus.req_i[1].valid = 1'b0;
      apply_stimulus(0, 1, 1, 32'h0);
      sample();
      check("wr done", 128'({bus.resp_o[1].data_ok, bus.resp_o[1].data_last}), 128'(2'b11));
      advance();
      apply_stimulus(0, 0, 0, 0);
      sample();
      check("wr dead valid", 128'(bus.bus_req_o.valid), 128'(0));
      advance();
      sample();
      check("wr next addr", 128'(bus.bus_req_o.addr), 128'(A0));
      check("wr next valid", 128'(bus.bus_req_o.valid), 128'(1));
      advance();
      finish_txn(0, 1);

      // Randomised traffic, every output checked against the model each cycle.
      for (int k = 0; k < N; k++) active[k] = 1'b0;
      for (int c = 0; c < 800; c++) begin
         for (int k = 0; k < N; k++) begin
            if (!active[k] && m_owner != k && $urandom_range(0, 3) == 0) begin
               set_req(k, 1, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 7));
               active[k] = 1'b1;
            end
         end
         apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 2) == 0, $urandom);
         rst_n = ($urandom_range(0, 63) != 0);
         cycle();
         for (int k = 0; k < N; k++) begin
            if (active[k] && m_owner == k && m_acc) begin
               bus.req_i[k].valid = 1'b0;
               active[k] = 1'b0;
            end
         end
      end
      rst_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
